// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: self-test sequencer for the two-input basic-gate unit.
// Walks {a,b} through 00,01,10,11, waits SETTLE cycles per vector, compares
// the seven gate outputs against locally computed values and reports the
// mismatch count plus the first failing vector and its bit mask.
module gate_bist_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] fail_vec,
    output logic [6:0] fail_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // Last value of the settle counter before moving on to CHECK.
    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [3:0] settle_cnt;
    logic [6:0] exp_resp;
    logic       mismatch;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_APPLY;
            S_APPLY:  state_nxt = (SETTLE == 0) ? S_CHECK : S_SETTLE;
            S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (idx == 2'd3) ? S_DONE : S_APPLY;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Expected gate response for the registered vector; X/Z on resp counts as a mismatch.
    always_comb begin
        exp_resp = {a & b, a | b, a ^ b, ~(a ^ b), ~(a & b), ~a, ~b};
        mismatch = (resp !== exp_resp);
    end

    assign busy = (state != S_IDLE);

    // Vector drive, settle timing and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a          <= 1'b0;
            b          <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_mask  <= '0;
            idx        <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pass      <= 1'b0;
                        err_cnt   <= '0;
                        fail_vec  <= '0;
                        fail_mask <= '0;
                        idx       <= '0;
                    end
                end
                S_APPLY: begin
                    {a, b}     <= idx;
                    settle_cnt <= '0;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 3'd1;
                        if (err_cnt == 3'd0) begin
                            fail_vec  <= {a, b};
                            fail_mask <= exp_resp ^ resp;
                        end
                    end
                    if (idx != 2'd3) begin
                        idx <= idx + 2'd1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    pass <= (err_cnt == 3'd0);
                end
                default: ;
            endcase
        end
    end

endmodule
